// File: rtl/alu_share_ctrl_pkg.sv
// Shared constants, ALU op codes and controller state encoding for the shared-ALU controller.
package alu_share_ctrl_pkg;

    localparam int ALU_OP_WIDTH   = 4;
    localparam int REG_DATA_WIDTH = 32;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR  = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA = 4'd7;

    typedef enum logic {
        ALU_SHARE_IDLE = 1'b0,
        ALU_SHARE_EXEC = 1'b1
    } alu_share_state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module alu_share_ctrl_rr_arb2 (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // 1 after reset so requester 0 wins the first tie
    logic last_grant;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_grant ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_grant <= 1'b1;
        end else if (accept_i) begin
            last_grant <= gnt_o[1];
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters: round-robin issue into a
// registered ALU stage and a per-requester result buffer (2-cycle request-to-response latency).
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int ALU_OPWIDTH = ALU_OP_WIDTH,
    parameter int DATA_WIDTH  = REG_DATA_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    // valid/ready on every channel: a transfer happens in a cycle where both are high; ready
    // may depend on valid but never the reverse, and payload is held while valid & !ready.
    input  logic                   req0_valid_i,
    output logic                   req0_ready_o,
    input  logic [ALU_OPWIDTH-1:0] req0_op_i,
    input  logic [DATA_WIDTH-1:0]  req0_s1_i,
    input  logic [DATA_WIDTH-1:0]  req0_s2_i,
    input  logic                   req1_valid_i,
    output logic                   req1_ready_o,
    input  logic [ALU_OPWIDTH-1:0] req1_op_i,
    input  logic [DATA_WIDTH-1:0]  req1_s1_i,
    input  logic [DATA_WIDTH-1:0]  req1_s2_i,
    output logic                   rsp0_valid_o,
    input  logic                   rsp0_ready_i,
    output logic [DATA_WIDTH-1:0]  rsp0_data_o,
    output logic                   rsp0_zero_o,
    output logic                   rsp1_valid_o,
    input  logic                   rsp1_ready_i,
    output logic [DATA_WIDTH-1:0]  rsp1_data_o,
    output logic                   rsp1_zero_o,
    output logic [ALU_OPWIDTH-1:0] alu_op_o,
    output logic [DATA_WIDTH-1:0]  alu_s1_o,
    output logic [DATA_WIDTH-1:0]  alu_s2_o,
    input  logic [DATA_WIDTH-1:0]  alu_d_i,
    input  logic                   alu_zero_i,
    output alu_share_state_t       state_o
);

    alu_share_state_t state, state_nxt;
    logic             owner;
    logic [1:0]       eligible;
    logic [1:0]       gnt;
    logic             accept;
    logic [1:0]       capture;
    logic [1:0]       rsp_ready;
    logic [1:0]       rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data [2];
    logic [1:0]       rsp_zero;

    assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};

    // A requester may issue only if its buffer will be free at capture time and it has nothing
    // already in the ALU stage; gating with rstn_i keeps both readies low during reset.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            eligible[n] = (!rsp_valid[n] || rsp_ready[n])
                       && !(state == ALU_SHARE_EXEC && owner == n[0])
                       && rstn_i;
        end
        eligible[0] = eligible[0] && req0_valid_i;
        eligible[1] = eligible[1] && req1_valid_i;
    end

    alu_share_ctrl_rr_arb2 u_arb (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .req_i    (eligible),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign accept       = |gnt;
    assign req0_ready_o = gnt[0];
    assign req1_ready_o = gnt[1];

    always_comb begin
        state_nxt = ALU_SHARE_IDLE;
        if (accept) begin
            state_nxt = ALU_SHARE_EXEC;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ALU_SHARE_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign state_o = state;

    // Issue registers keep their last values while idle so the ALU inputs do not toggle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner    <= 1'b0;
            alu_op_o <= '0;
            alu_s1_o <= '0;
            alu_s2_o <= '0;
        end else if (accept) begin
            owner    <= gnt[1];
            alu_op_o <= gnt[1] ? req1_op_i : req0_op_i;
            alu_s1_o <= gnt[1] ? req1_s1_i : req0_s1_i;
            alu_s2_o <= gnt[1] ? req1_s2_i : req0_s2_i;
        end
    end

    assign capture[0] = (state == ALU_SHARE_EXEC) && !owner;
    assign capture[1] = (state == ALU_SHARE_EXEC) &&  owner;

    // A capture at the same edge as a consume wins: the buffer stays valid with the new result.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rsp_valid <= '0;
            rsp_zero  <= '0;
            for (int n = 0; n < 2; n++) begin
                rsp_data[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (capture[n]) begin
                    rsp_valid[n] <= 1'b1;
                    rsp_data[n]  <= alu_d_i;
                    rsp_zero[n]  <= alu_zero_i;
                end else if (rsp_valid[n] && rsp_ready[n]) begin
                    rsp_valid[n] <= 1'b0;
                    rsp_data[n]  <= '0;
                    rsp_zero[n]  <= 1'b0;
                end
            end
        end
    end

    assign rsp0_valid_o = rsp_valid[0];
    assign rsp0_data_o  = rsp_data[0];
    assign rsp0_zero_o  = rsp_zero[0];
    assign rsp1_valid_o = rsp_valid[1];
    assign rsp1_data_o  = rsp_data[1];
    assign rsp1_zero_o  = rsp_zero[1];

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl with a small behavioural ALU attached to its ALU ports.
module tb_alu_share_ctrl;
    import alu_share_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [3:0]  req0_op_i, req1_op_i;
    logic [31:0] req0_s1_i, req0_s2_i, req1_s1_i, req1_s2_i;
    logic        rsp0_valid_o, rsp1_valid_o;
    logic        rsp0_ready_i, rsp1_ready_i;
    logic [31:0] rsp0_data_o, rsp1_data_o;
    logic        rsp0_zero_o, rsp1_zero_o;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_s1_o, alu_s2_o;
    logic [31:0] alu_d_i;
    logic        alu_zero_i;
    alu_share_state_t state_o;

    alu_share_ctrl dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_op_i    (req0_op_i),
        .req0_s1_i    (req0_s1_i),
        .req0_s2_i    (req0_s2_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_op_i    (req1_op_i),
        .req1_s1_i    (req1_s1_i),
        .req1_s2_i    (req1_s2_i),
        .rsp0_valid_o (rsp0_valid_o),
        .rsp0_ready_i (rsp0_ready_i),
        .rsp0_data_o  (rsp0_data_o),
        .rsp0_zero_o  (rsp0_zero_o),
        .rsp1_valid_o (rsp1_valid_o),
        .rsp1_ready_i (rsp1_ready_i),
        .rsp1_data_o  (rsp1_data_o),
        .rsp1_zero_o  (rsp1_zero_o),
        .alu_op_o     (alu_op_o),
        .alu_s1_o     (alu_s1_o),
        .alu_s2_o     (alu_s2_o),
        .alu_d_i      (alu_d_i),
        .alu_zero_i   (alu_zero_i),
        .state_o      (state_o)
    );

    // Behavioural ALU; undefined codes produce 0.
    always_comb begin
        alu_d_i = '0;
        case (alu_op_o)
            ALU_OP_ADD: alu_d_i = alu_s1_o + alu_s2_o;
            ALU_OP_SUB: alu_d_i = alu_s1_o - alu_s2_o;
            ALU_OP_AND: alu_d_i = alu_s1_o & alu_s2_o;
            ALU_OP_OR:  alu_d_i = alu_s1_o | alu_s2_o;
            ALU_OP_SLL: alu_d_i = alu_s1_o << alu_s2_o[4:0];
            ALU_OP_XOR: alu_d_i = alu_s1_o ^ alu_s2_o;
            ALU_OP_SRL: alu_d_i = alu_s1_o >> alu_s2_o[4:0];
            ALU_OP_SRA: alu_d_i = $unsigned($signed(alu_s1_o) >>> alu_s2_o[4:0]);
            default:    alu_d_i = '0;
        endcase
    end
    assign alu_zero_i = (alu_d_i == 32'd0);

    // Clock / reset
    always #5 clk_i = ~clk_i;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        port;
        logic [3:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] exp_d;
        logic        exp_z;
    } vec_t;

    vec_t vecs[8];

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    int          nresp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Driver tasks
    task automatic idle_inputs();
        req0_valid_i = 1'b0; req0_op_i = '0; req0_s1_i = '0; req0_s2_i = '0;
        req1_valid_i = 1'b0; req1_op_i = '0; req1_s1_i = '0; req1_s2_i = '0;
        rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    endtask

    task automatic drive0(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2);
        req0_valid_i = 1'b1; req0_op_i = op; req0_s1_i = s1; req0_s2_i = s2;
    endtask

    task automatic drive1(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2);
        req1_valid_i = 1'b1; req1_op_i = op; req1_s1_i = s1; req1_s2_i = s2;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rstn_i = 1'b1;
    endtask

    // One isolated transaction from the vector table: accept, issue, response, consume.
    task automatic run_vec(input int idx, input vec_t v);
        int   n;
        logic got;
        if (!v.port) drive0(v.op, v.s1, v.s2);
        else         drive1(v.op, v.s1, v.s2);
        settle();
        n = 0;
        got = v.port ? req1_ready_o : req0_ready_o;
        while (!got && n < 8) begin
            tick(); settle();
            n++;
            got = v.port ? req1_ready_o : req0_ready_o;
        end
        check($sformatf("vec%0d accept", idx), got, 1);
        check($sformatf("vec%0d other ready", idx), v.port ? req0_ready_o : req1_ready_o, 0);
        tick();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        settle();
        check($sformatf("vec%0d alu_op", idx), alu_op_o, v.op);
        check($sformatf("vec%0d alu_s1", idx), alu_s1_o, v.s1);
        check($sformatf("vec%0d alu_s2", idx), alu_s2_o, v.s2);
        check($sformatf("vec%0d early rsp", idx), v.port ? rsp1_valid_o : rsp0_valid_o, 0);
        tick(); settle();
        check($sformatf("vec%0d rsp valid", idx), v.port ? rsp1_valid_o : rsp0_valid_o, 1);
        check($sformatf("vec%0d rsp data", idx), v.port ? rsp1_data_o : rsp0_data_o, v.exp_d);
        check($sformatf("vec%0d rsp zero", idx), v.port ? rsp1_zero_o : rsp0_zero_o, v.exp_z);
        tick(); settle();
        check($sformatf("vec%0d rsp consumed", idx), v.port ? rsp1_valid_o : rsp0_valid_o, 0);
        check($sformatf("vec%0d idle state", idx), state_o, ALU_SHARE_IDLE);
        check($sformatf("vec%0d alu hold", idx), alu_s1_o, v.s1);
    endtask

    // Scoreboard: each valid response cycle pops one expected {zero, data}.
    task automatic sb_check();
        logic [32:0] e;
        if (rsp0_valid_o) begin
            if (exp_q0.size() == 0) begin
                check("sb rsp0 unexpected", 1, 0);
            end else begin
                e = exp_q0.pop_front();
                check("sb rsp0 data", rsp0_data_o, e[31:0]);
                check("sb rsp0 zero", rsp0_zero_o, e[32]);
                nresp++;
            end
        end
        if (rsp1_valid_o) begin
            if (exp_q1.size() == 0) begin
                check("sb rsp1 unexpected", 1, 0);
            end else begin
                e = exp_q1.pop_front();
                check("sb rsp1 data", rsp1_data_o, e[31:0]);
                check("sb rsp1 zero", rsp1_zero_o, e[32]);
                nresp++;
            end
        end
    endtask

    initial begin
        logic [31:0] a0, b1, j;
        logic        acc0, acc1;

        vecs[0] = '{1'b0, ALU_OP_ADD, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1] = '{1'b0, ALU_OP_SUB, 32'd3,          32'd3,          32'd0,          1'b1};
        vecs[2] = '{1'b1, ALU_OP_XOR, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0};
        vecs[3] = '{1'b1, ALU_OP_SRA, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0};
        vecs[4] = '{1'b0, ALU_OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[5] = '{1'b1, ALU_OP_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[6] = '{1'b0, 4'hF,       32'h1234_5678,  32'h9ABC_DEF0,  32'd0,          1'b1};
        vecs[7] = '{1'b1, ALU_OP_SRA, 32'h4000_0000,  32'd30,         32'd1,          1'b0};

        // Reset state, with both requests valid to show ready stays low in reset
        idle_inputs();
        rstn_i = 1'b0;
        drive0(ALU_OP_ADD, 32'd1, 32'd1);
        drive1(ALU_OP_ADD, 32'd2, 32'd2);
        repeat (2) tick();
        settle();
        check("reset req0_ready", req0_ready_o, 0);
        check("reset req1_ready", req1_ready_o, 0);
        check("reset rsp0_valid", rsp0_valid_o, 0);
        check("reset rsp1_valid", rsp1_valid_o, 0);
        check("reset rsp0_data", rsp0_data_o, 0);
        check("reset rsp1_zero", rsp1_zero_o, 0);
        check("reset alu_s1", alu_s1_o, 0);
        check("reset alu_op", alu_op_o, 0);
        check("reset state", state_o, ALU_SHARE_IDLE);
        tick();
        idle_inputs();
        rstn_i = 1'b1;

        // Single-transaction vectors (ADD, SUB zero, XOR, SRA, wrap, undefined op)
        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // Simultaneous requests after reset: req0 first, req1 next cycle
        do_reset();
        drive0(ALU_OP_SUB, 32'd3, 32'd3);
        drive1(ALU_OP_XOR, 32'h0000_00F0, 32'h0000_000F);
        settle();
        check("tie c0 req0_ready", req0_ready_o, 1);
        check("tie c0 req1_ready", req1_ready_o, 0);
        tick();
        req0_valid_i = 1'b0;
        settle();
        check("tie c1 req1_ready", req1_ready_o, 1);
        check("tie c1 req0_ready", req0_ready_o, 0);
        tick();
        req1_valid_i = 1'b0;
        settle();
        check("tie c2 rsp0_valid", rsp0_valid_o, 1);
        check("tie c2 rsp0_data", rsp0_data_o, 0);
        check("tie c2 rsp0_zero", rsp0_zero_o, 1);
        check("tie c2 rsp1_valid", rsp1_valid_o, 0);
        tick(); settle();
        check("tie c3 rsp1_valid", rsp1_valid_o, 1);
        check("tie c3 rsp1_data", rsp1_data_o, 32'h0000_00FF);
        check("tie c3 rsp1_zero", rsp1_zero_o, 0);
        check("tie c3 rsp0_valid", rsp0_valid_o, 0);
        tick();

        // Both requesters saturating: grants alternate, no response lost or duplicated
        do_reset();
        exp_q0.delete(); exp_q1.delete();
        nresp = 0;
        a0 = 32'd10; b1 = 32'd1;
        drive0(ALU_OP_ADD, a0, 32'd1);
        drive1(ALU_OP_XOR, b1, 32'h0000_00FF);
        for (int c = 0; c < 8; c++) begin
            settle();
            check($sformatf("rr c%0d req0_ready", c), req0_ready_o, (c % 2 == 0) ? 1 : 0);
            check($sformatf("rr c%0d req1_ready", c), req1_ready_o, (c % 2 == 1) ? 1 : 0);
            sb_check();
            acc0 = req0_ready_o;
            acc1 = req1_ready_o;
            if (acc0) exp_q0.push_back({(a0 + 32'd1) == 32'd0, a0 + 32'd1});
            if (acc1) exp_q1.push_back({(b1 ^ 32'h0000_00FF) == 32'd0, b1 ^ 32'h0000_00FF});
            tick();
            if (acc0) begin a0 = a0 + 32'd7; drive0(ALU_OP_ADD, a0, 32'd1); end
            if (acc1) begin b1 = b1 + 32'd3; drive1(ALU_OP_XOR, b1, 32'h0000_00FF); end
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            sb_check();
            tick();
        end
        check("rr response count", nresp, 8);
        check("rr q0 empty", exp_q0.size(), 0);
        check("rr q1 empty", exp_q1.size(), 0);

        // Backpressure on rsp0: buffer held, req0 blocked, req1 still served every 2 cycles
        do_reset();
        rsp0_ready_i = 1'b0;
        drive0(ALU_OP_ADD, 32'd1, 32'd1);
        j = 32'd1;
        drive1(ALU_OP_XOR, j, 32'd0);
        settle();
        check("bp c0 req0_ready", req0_ready_o, 1);
        tick();
        drive0(ALU_OP_ADD, 32'd2, 32'd2);
        settle();
        check("bp c1 req1_ready", req1_ready_o, 1);
        check("bp c1 req0_ready", req0_ready_o, 0);
        tick();
        j = 32'd2;
        drive1(ALU_OP_XOR, j, 32'd0);
        for (int c = 2; c < 8; c++) begin
            settle();
            check($sformatf("bp c%0d rsp0_valid", c), rsp0_valid_o, 1);
            check($sformatf("bp c%0d rsp0_data", c), rsp0_data_o, 32'd2);
            check($sformatf("bp c%0d req0_ready", c), req0_ready_o, 0);
            check($sformatf("bp c%0d req1_ready", c), req1_ready_o, c % 2);
            check($sformatf("bp c%0d rsp1_valid", c), rsp1_valid_o, c % 2);
            if (c % 2 == 1) check($sformatf("bp c%0d rsp1_data", c), rsp1_data_o, (c - 1) / 2);
            acc1 = req1_ready_o;
            tick();
            if (acc1) begin j = j + 32'd1; drive1(ALU_OP_XOR, j, 32'd0); end
        end
        req1_valid_i = 1'b0;
        rsp0_ready_i = 1'b1;
        settle();
        check("bp drain req0_ready", req0_ready_o, 1);
        check("bp drain rsp0_data", rsp0_data_o, 32'd2);
        tick();
        req0_valid_i = 1'b0;
        settle();
        check("bp c9 rsp0_valid", rsp0_valid_o, 0);
        check("bp c9 alu_s1", alu_s1_o, 32'd2);
        check("bp c9 rsp1_data", rsp1_data_o, 32'd4);
        tick(); settle();
        check("bp c10 rsp0_valid", rsp0_valid_o, 1);
        check("bp c10 rsp0_data", rsp0_data_o, 32'd4);
        tick();

        // Reset while an op is in flight: everything clears at once, the op is dropped
        do_reset();
        drive0(ALU_OP_ADD, 32'd5, 32'd7);
        settle();
        check("rst c0 req0_ready", req0_ready_o, 1);
        tick(); settle();
        check("rst c1 state", state_o, ALU_SHARE_EXEC);
        rstn_i = 1'b0;
        #1;
        check("rst async state", state_o, ALU_SHARE_IDLE);
        check("rst async alu_s1", alu_s1_o, 0);
        check("rst async alu_s2", alu_s2_o, 0);
        check("rst async req0_ready", req0_ready_o, 0);
        check("rst async rsp0_valid", rsp0_valid_o, 0);
        tick();
        rstn_i = 1'b1;
        req0_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("rst drop c%0d rsp0_valid", c), rsp0_valid_o, 0);
            tick();
        end
        drive0(ALU_OP_ADD, 32'd1, 32'd2);
        drive1(ALU_OP_ADD, 32'd3, 32'd4);
        settle();
        check("rst first req0_ready", req0_ready_o, 1);
        check("rst first req1_ready", req1_ready_o, 0);
        tick();
        idle_inputs();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
